matrix_store_writer: RTL and testbench
======================================

Name: matrix_store_writer

Overview:
- Responder end of the storage-manager write interface that the compute path drives (request/ready, then streamed data words, then done).
- Accepts one matrix write per transaction and validates its ID and dimensions.
- Writes a 3-word header plus row-major data into that matrix's BRAM block, then pulses write_done.
- Tracks per-slot validity so readers only see fully written matrices.

Parameters:
- BLOCK_SIZE, 1152, words reserved per matrix slot.
- DATA_WIDTH, 32, BRAM word width.
- ADDR_WIDTH, 14, BRAM address width.
- NUM_SLOTS, 8, number of matrix slots; IDs 0..NUM_SLOTS-1.
- MAX_DIM, 32, maximum rows and maximum cols.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- write_request  in  1  initiator requests a transaction
- write_ready  out  1  responder can accept a request
- write_matrix_id  in  3  target slot
- write_rows  in  8  row count
- write_cols  in  8  column count
- write_name  in  8 x 8 (unpacked [0:7])  ASCII name
- write_data  in  DATA_WIDTH  data word
- write_data_valid  in  1  data word valid
- writer_ready  out  1  responder accepts data this cycle
- write_done  out  1  one-cycle pulse, transaction committed
- write_error  out  1  one-cycle pulse, request rejected
- abort  in  1  cancel current transaction
- bram_wr_en  out  1  BRAM write strobe
- bram_wr_addr  out  ADDR_WIDTH  BRAM write address
- bram_wr_data  out  DATA_WIDTH  BRAM write data
- slot_valid  out  NUM_SLOTS  per-slot committed flag

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - State IDLE.
  - write_ready=1; writer_ready, write_done, write_error, bram_wr_en = 0.
  - bram_wr_addr=0, bram_wr_data=0, slot_valid=0, all counters 0.
- States: IDLE, CHECK, HEADER, DATA, DONE.
- IDLE:
  - write_ready=1.
  - Accept when write_request && write_ready.
  - Latch id, rows, cols and name; go to CHECK.
  - write_ready is low in every state other than IDLE.
- CHECK (1 cycle):
  - Valid iff id<NUM_SLOTS, 1<=rows<=MAX_DIM and 1<=cols<=MAX_DIM.
  - Invalid: write_error pulses 1 cycle, slot_valid unchanged, no BRAM write, return to IDLE.
  - Valid:
    - Clear slot_valid[id].
    - base = id*BLOCK_SIZE, computed in ADDR_WIDTH bits with no overflow at defaults.
    - total = rows*cols, 16-bit.
    - Go to HEADER.
- HEADER (3 cycles), one BRAM write per cycle:
  - base+0 = {16'h0, rows, cols}.
  - base+1 = {name[0], name[1], name[2], name[3]}.
  - base+2 = {name[4], name[5], name[6], name[7]}.
  - writer_ready=0 throughout.
- DATA:
  - writer_ready=1 (registered).
  - Word transfers only when write_data_valid && writer_ready. It is written to base+3+cnt; cnt then increments.
  - Gaps in valid are allowed, with no timeout.
  - When the word with cnt==total-1 is accepted, go to DONE. writer_ready is 0 on the next cycle, so any extra valid words are ignored.
- DONE (1 cycle):
  - write_done=1 and slot_valid[id] is set.
  - Return to IDLE.
- BRAM port latency: bram_wr_* registered, one cycle after the header step or data acceptance. bram_wr_en is high only for exactly those cycles.
- abort:
  - In CHECK, HEADER or DATA: return to IDLE next cycle.
  - slot_valid[id] stays 0; no write_done or write_error.
  - Any BRAM write already registered completes; no further writes.
  - Ignored in IDLE and DONE.
- Simultaneous abort and final data word: abort wins, the slot is not committed.
- Overwriting a valid slot: its flag clears in CHECK and is only re-set in DONE.
- Reset mid-operation: everything returns to reset values, and all slots become invalid.

Decomposition:
- Shared package matrix_store_pkg:
  - HEADER_WORDS=3.
  - store_state_t enum.
  - Header field offsets (HDR_DIM_OFS=0, HDR_NAME0_OFS=1, HDR_NAME1_OFS=2).
  - A pack_name_word function.
  - Readers reuse this package.
- No sub-module needed; a single FSM with a datapath counter suffices.

Test Plan:
- Basic write, 2x3, id=1, name "MATA", data 1..6:
  - Header writes at 1152/1153/1154 with data 0x00000203 / 0x4D415441 / 0x00000000.
  - Data writes at 1155..1160 with values 1..6.
  - write_done pulses one cycle after the last data acceptance; slot_valid=8'h02.
- Invalid requests (rows=0, cols=3) and (rows=33, cols=1), each issued alone:
  - Each gives a write_error pulse 2 cycles after acceptance.
  - bram_wr_en never asserts; slot_valid unchanged.
- Backpressure, 1x4, id=0, valid toggling 1,0,0,1,1,0,1:
  - Exactly 4 data writes at 3..6, in order.
  - A 5th valid word after done produces no write.
- Abort during DATA (id=2, 3x3, abort after 4 words):
  - Returns to IDLE; no write_done.
  - slot_valid[2]=0, even if it was previously 1.
- Maximum 32x32, id=7:
  - Last data address is 7*1152+3+1023 = 9090.
  - write_done pulses and slot_valid[7]=1.
- Reset asserted mid-HEADER:
  - All outputs return to reset values immediately.
  - After release, a new 1x1 write to id=0 completes normally.

Source files
------------

// File: rtl/matrix_store_pkg.sv
// Shared definitions for the matrix store: FSM encoding, header layout and name packing.
// Reader-side logic imports this package so both ends agree on the slot layout.
package matrix_store_pkg;

    localparam int HEADER_WORDS = 3;

    typedef logic [2:0] store_state_t;

    localparam store_state_t ST_IDLE   = 3'd0;
    localparam store_state_t ST_CHECK  = 3'd1;
    localparam store_state_t ST_HEADER = 3'd2;
    localparam store_state_t ST_DATA   = 3'd3;
    localparam store_state_t ST_DONE   = 3'd4;

    localparam logic [1:0] HDR_DIM_OFS   = 2'd0;
    localparam logic [1:0] HDR_NAME0_OFS = 2'd1;
    localparam logic [1:0] HDR_NAME1_OFS = 2'd2;

    // First character lands in the most significant byte.
    function automatic logic [31:0] pack_name_word(input logic [7:0] c0, input logic [7:0] c1,
                                                   input logic [7:0] c2, input logic [7:0] c3);
        return {c0, c1, c2, c3};
    endfunction

endpackage

// File: rtl/matrix_store_writer.sv
// Write-side responder of the storage manager: validates a matrix write, stores a 3-word
// header plus row-major data into the slot's BRAM block, and tracks per-slot validity.
module matrix_store_writer
    import matrix_store_pkg::*;
#(
    parameter int BLOCK_SIZE = 1152,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int NUM_SLOTS  = 8,
    parameter int MAX_DIM    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_request,
    output logic                  write_ready,
    input  logic [2:0]            write_matrix_id,
    input  logic [7:0]            write_rows,
    input  logic [7:0]            write_cols,
    input  logic [7:0]            write_name [0:7],
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_data_valid,
    output logic                  writer_ready,
    output logic                  write_done,
    output logic                  write_error,
    input  logic                  abort,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic [NUM_SLOTS-1:0]  slot_valid
);

    store_state_t          state_q, state_d;
    logic [2:0]            id_q, id_d;
    logic [7:0]            rows_q, rows_d;
    logic [7:0]            cols_q, cols_d;
    logic [7:0]            name_q [0:7];
    logic [7:0]            name_d [0:7];
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [15:0]           total_q, total_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic                  ready_q, ready_d;
    logic                  wready_q, wready_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_SLOTS-1:0]  slot_valid_q, slot_valid_d;
    logic                  req_ok;

    assign req_ok = (32'(id_q) < NUM_SLOTS)
                 && (rows_q != 8'd0) && (32'(rows_q) <= MAX_DIM)
                 && (cols_q != 8'd0) && (32'(cols_q) <= MAX_DIM);

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        name_d       = name_q;
        base_d       = base_q;
        total_d      = total_q;
        cnt_d        = cnt_q;
        hdr_cnt_d    = hdr_cnt_q;
        slot_valid_d = slot_valid_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        done_d       = 1'b0;
        error_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (write_request && ready_q) begin
                    id_d    = write_matrix_id;
                    rows_d  = write_rows;
                    cols_d  = write_cols;
                    name_d  = write_name;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // A valid target loses its committed flag even if this transfer is aborted.
                if (req_ok) begin
                    slot_valid_d[id_q] = 1'b0;
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!req_ok) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    base_d    = ADDR_WIDTH'(32'(id_q) * BLOCK_SIZE);
                    total_d   = {8'h00, rows_q} * {8'h00, cols_q};
                    cnt_d     = 16'd0;
                    hdr_cnt_d = 2'd0;
                    state_d   = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + ADDR_WIDTH'(hdr_cnt_q);
                    case (hdr_cnt_q)
                        HDR_DIM_OFS:   wr_data_d = DATA_WIDTH'({16'h0000, rows_q, cols_q});
                        HDR_NAME0_OFS: wr_data_d = DATA_WIDTH'(pack_name_word(name_q[0], name_q[1],
                                                                              name_q[2], name_q[3]));
                        default:       wr_data_d = DATA_WIDTH'(pack_name_word(name_q[4], name_q[5],
                                                                              name_q[6], name_q[7]));
                    endcase
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == HDR_NAME1_OFS) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (write_data_valid && wready_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + ADDR_WIDTH'(HEADER_WORDS) + ADDR_WIDTH'(cnt_q);
                    wr_data_d = write_data;
                    cnt_d     = cnt_q + 16'd1;
                    if (cnt_q == total_q - 16'd1) begin
                        slot_valid_d[id_q] = 1'b1;
                        done_d             = 1'b1;
                        state_d            = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d  = (state_d == ST_IDLE);
        wready_d = (state_d == ST_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            name_q       <= '{default: '0};
            base_q       <= '0;
            total_q      <= '0;
            cnt_q        <= '0;
            hdr_cnt_q    <= '0;
            ready_q      <= 1'b1;
            wready_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            slot_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            name_q       <= name_d;
            base_q       <= base_d;
            total_q      <= total_d;
            cnt_q        <= cnt_d;
            hdr_cnt_q    <= hdr_cnt_d;
            ready_q      <= ready_d;
            wready_q     <= wready_d;
            done_q       <= done_d;
            error_q      <= error_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            slot_valid_q <= slot_valid_d;
        end
    end

    assign write_ready  = ready_q;
    assign writer_ready = wready_q;
    assign write_done   = done_q;
    assign write_error  = error_q;
    assign bram_wr_en   = wr_en_q;
    assign bram_wr_addr = wr_addr_q;
    assign bram_wr_data = wr_data_q;
    assign slot_valid   = slot_valid_q;

endmodule

// File: tb/tb_matrix_store_writer.sv
// Directed bench for matrix_store_writer: request validation table plus hand-built
// sequences for backpressure, abort, maximum size and mid-transfer reset.
module tb_matrix_store_writer;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int NS = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_request;
    logic          write_ready;
    logic [2:0]    write_matrix_id;
    logic [7:0]    write_rows;
    logic [7:0]    write_cols;
    logic [7:0]    write_name [0:7];
    logic [DW-1:0] write_data;
    logic          write_data_valid;
    logic          writer_ready;
    logic          write_done;
    logic          write_error;
    logic          abort;
    logic          bram_wr_en;
    logic [AW-1:0] bram_wr_addr;
    logic [DW-1:0] bram_wr_data;
    logic [NS-1:0] slot_valid;

    matrix_store_writer dut (
        .clk(clk), .rst_n(rst_n),
        .write_request(write_request), .write_ready(write_ready),
        .write_matrix_id(write_matrix_id), .write_rows(write_rows), .write_cols(write_cols),
        .write_name(write_name), .write_data(write_data), .write_data_valid(write_data_valid),
        .writer_ready(writer_ready), .write_done(write_done), .write_error(write_error),
        .abort(abort), .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr),
        .bram_wr_data(bram_wr_data), .slot_valid(slot_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];

    always @(negedge clk) begin
        if (rst_n && bram_wr_en) begin
            log_addr.push_back(bram_wr_addr);
            log_data.push_back(bram_wr_data);
        end
    end

    typedef struct {
        logic [2:0]    id;
        logic [7:0]    rows;
        logic [7:0]    cols;
        bit            exp_err;
        logic [NS-1:0] exp_slots;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue_request(input logic [2:0] id, input logic [7:0] rows,
                                 input logic [7:0] cols, input logic [63:0] nm);
        chk("req_ready", 64'(write_ready), 64'd1);
        write_matrix_id = id;
        write_rows      = rows;
        write_cols      = cols;
        for (int i = 0; i < 8; i++) write_name[i] = nm[63-8*i -: 8];
        write_request = 1'b1;
        step();
        write_request = 1'b0;
    endtask

    task automatic run_write(input logic [2:0] id, input logic [7:0] rows, input logic [7:0] cols,
                             input logic [63:0] nm, input logic [31:0] d0, input logic [15:0] pat,
                             input int abort_after, input bit hold_valid, output bit done_seen);
        int  total;
        int  acc;
        int  w;
        bit  rdy;
        bit  v;
        bit  finished;
        total     = int'(rows) * int'(cols);
        done_seen = 1'b0;
        issue_request(id, rows, cols, nm);
        w = 0;
        while (!writer_ready && w < 10) begin
            step();
            w++;
        end
        if (!writer_ready) begin
            checks++;
            errors++;
            $display("FAIL wr_ready_timeout: writer_ready stayed 0 for id %0d", id);
            return;
        end
        acc      = 0;
        finished = 1'b0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            if (acc == abort_after) begin
                abort            = 1'b1;
                write_data_valid = 1'b0;
                step();
                abort = 1'b0;
                chk("abort_idle", 64'(write_ready), 64'd1);
                chk("abort_no_done", 64'(write_done), 64'd0);
                return;
            end
            v                = pat[c % 16];
            rdy              = writer_ready;
            write_data_valid = v;
            write_data       = d0 + 32'(acc);
            step();
            if (v && rdy) acc++;
            if (acc == total) finished = 1'b1;
        end
        if (!finished) begin
            checks++;
            errors++;
            write_data_valid = 1'b0;
            $display("FAIL data_timeout: accepted %0d of %0d words", acc, total);
            return;
        end
        if (hold_valid) write_data = 32'hDEADBEEF;
        else            write_data_valid = 1'b0;
        done_seen = write_done;
        chk("done_pulse", 64'(write_done), 64'd1);
        chk("done_wready_low", 64'(writer_ready), 64'd0);
        step();
        chk("done_clear", 64'(write_done), 64'd0);
    endtask

    task automatic run_bad(input logic [2:0] id, input logic [7:0] rows, input logic [7:0] cols,
                           input logic [NS-1:0] exp_slots);
        int s;
        s = log_addr.size();
        issue_request(id, rows, cols, 64'h0);
        chk("err_in_check", 64'(write_error), 64'd0);
        step();
        chk("err_pulse", 64'(write_error), 64'd1);
        chk("err_slots", 64'(slot_valid), 64'(exp_slots));
        step();
        chk("err_clear", 64'(write_error), 64'd0);
        chk("err_no_bram", 64'(log_addr.size() - s), 64'd0);
    endtask

    initial begin
        vec_t vecs [6];
        bit   dn;
        int   s;

        write_request    = 1'b0;
        write_matrix_id  = '0;
        write_rows       = '0;
        write_cols       = '0;
        write_data       = '0;
        write_data_valid = 1'b0;
        abort            = 1'b0;
        for (int i = 0; i < 8; i++) write_name[i] = 8'h00;

        vecs[0] = '{3'd1, 8'd0,  8'd3,  1'b1, 8'h02};
        vecs[1] = '{3'd1, 8'd33, 8'd1,  1'b1, 8'h02};
        vecs[2] = '{3'd6, 8'd4,  8'd0,  1'b1, 8'h02};
        vecs[3] = '{3'd6, 8'd1,  8'd33, 1'b1, 8'h02};
        vecs[4] = '{3'd4, 8'd1,  8'd1,  1'b0, 8'h12};
        vecs[5] = '{3'd5, 8'd32, 8'd1,  1'b0, 8'h32};

        step(); step(); step();
        chk("rst_write_ready", 64'(write_ready), 64'd1);
        chk("rst_writer_ready", 64'(writer_ready), 64'd0);
        chk("rst_done", 64'(write_done), 64'd0);
        chk("rst_error", 64'(write_error), 64'd0);
        chk("rst_wr_en", 64'(bram_wr_en), 64'd0);
        chk("rst_addr", 64'(bram_wr_addr), 64'd0);
        chk("rst_data", 64'(bram_wr_data), 64'd0);
        chk("rst_slots", 64'(slot_valid), 64'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 64'(write_ready), 64'd1);

        // Basic 2x3 write into slot 1
        s = log_addr.size();
        run_write(3'd1, 8'd2, 8'd3, {"MATA", 32'h0}, 32'd1, 16'hFFFF, -1, 1'b0, dn);
        chk("basic_done", 64'(dn), 64'd1);
        chk("basic_nwr", 64'(log_addr.size() - s), 64'd9);
        if (log_addr.size() - s == 9) begin
            chk("basic_h0_addr", 64'(log_addr[s]),   64'd1152);
            chk("basic_h0_data", 64'(log_data[s]),   64'h00000203);
            chk("basic_h1_addr", 64'(log_addr[s+1]), 64'd1153);
            chk("basic_h1_data", 64'(log_data[s+1]), 64'h4D415441);
            chk("basic_h2_addr", 64'(log_addr[s+2]), 64'd1154);
            chk("basic_h2_data", 64'(log_data[s+2]), 64'h00000000);
            for (int i = 0; i < 6; i++) begin
                chk("basic_d_addr", 64'(log_addr[s+3+i]), 64'(1155 + i));
                chk("basic_d_data", 64'(log_data[s+3+i]), 64'(i + 1));
            end
        end
        chk("basic_slots", 64'(slot_valid), 64'h02);

        // Request validation table
        for (int k = 0; k < 6; k++) begin
            if (vecs[k].exp_err) begin
                run_bad(vecs[k].id, vecs[k].rows, vecs[k].cols, vecs[k].exp_slots);
            end else begin
                s = log_addr.size();
                run_write(vecs[k].id, vecs[k].rows, vecs[k].cols, {"T", 56'h0}, 32'h100,
                          16'hFFFF, -1, 1'b0, dn);
                chk("tbl_done", 64'(dn), 64'd1);
                chk("tbl_nwr", 64'(log_addr.size() - s),
                    64'(3 + int'(vecs[k].rows) * int'(vecs[k].cols)));
                chk("tbl_slots", 64'(slot_valid), 64'(vecs[k].exp_slots));
            end
        end

        // Backpressure 1x4 into slot 0, valid pattern 1,0,0,1,1,0,1 then held high
        s = log_addr.size();
        run_write(3'd0, 8'd1, 8'd4, {"BP", 48'h0}, 32'hA0, 16'h0059, -1, 1'b1, dn);
        step(); step(); step();
        write_data_valid = 1'b0;
        chk("bp_done", 64'(dn), 64'd1);
        chk("bp_nwr", 64'(log_addr.size() - s), 64'd7);
        if (log_addr.size() - s == 7) begin
            chk("bp_h0_addr", 64'(log_addr[s]), 64'd0);
            chk("bp_h0_data", 64'(log_data[s]), 64'h00000104);
            for (int i = 0; i < 4; i++) begin
                chk("bp_d_addr", 64'(log_addr[s+3+i]), 64'(3 + i));
                chk("bp_d_data", 64'(log_data[s+3+i]), 64'(32'hA0 + i));
            end
        end
        chk("bp_slots", 64'(slot_valid), 64'h33);

        // Commit slot 2, then overwrite it and abort after 4 words
        run_write(3'd2, 8'd3, 8'd3, {"AB", 48'h0}, 32'h200, 16'hFFFF, -1, 1'b0, dn);
        chk("ab_pre_slots", 64'(slot_valid), 64'h37);
        s = log_addr.size();
        run_write(3'd2, 8'd3, 8'd3, {"AB", 48'h0}, 32'h300, 16'hFFFF, 4, 1'b0, dn);
        chk("ab_no_done_flag", 64'(dn), 64'd0);
        step();
        chk("ab_no_done_late", 64'(write_done), 64'd0);
        step();
        chk("ab_slots", 64'(slot_valid), 64'h33);
        chk("ab_nwr", 64'(log_addr.size() - s), 64'd7);

        // Maximum 32x32 into slot 7
        s = log_addr.size();
        run_write(3'd7, 8'd32, 8'd32, {"BIG", 40'h0}, 32'd0, 16'hFFFF, -1, 1'b0, dn);
        chk("max_done", 64'(dn), 64'd1);
        chk("max_nwr", 64'(log_addr.size() - s), 64'd1027);
        if (log_addr.size() - s == 1027) begin
            chk("max_first_addr", 64'(log_addr[s+3]), 64'd8067);
            chk("max_last_addr", 64'(log_addr[s+1026]), 64'd9090);
            chk("max_last_data", 64'(log_data[s+1026]), 64'd1023);
        end
        chk("max_slots", 64'(slot_valid), 64'hB3);

        // Reset asserted in the middle of the header
        issue_request(3'd3, 8'd2, 8'd2, {"RS", 48'h0});
        step(); step();
        chk("rs_in_header", 64'(bram_wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_write_ready", 64'(write_ready), 64'd1);
        chk("rs_writer_ready", 64'(writer_ready), 64'd0);
        chk("rs_wr_en", 64'(bram_wr_en), 64'd0);
        chk("rs_addr", 64'(bram_wr_addr), 64'd0);
        chk("rs_data", 64'(bram_wr_data), 64'd0);
        chk("rs_slots", 64'(slot_valid), 64'd0);
        chk("rs_done", 64'(write_done), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        s = log_addr.size();
        run_write(3'd0, 8'd1, 8'd1, {"X", 56'h0}, 32'h55, 16'hFFFF, -1, 1'b0, dn);
        chk("rs_new_done", 64'(dn), 64'd1);
        chk("rs_new_slots", 64'(slot_valid), 64'h01);
        chk("rs_new_nwr", 64'(log_addr.size() - s), 64'd4);
        if (log_addr.size() - s == 4) begin
            chk("rs_new_addr", 64'(log_addr[s+3]), 64'd3);
            chk("rs_new_data", 64'(log_data[s+3]), 64'h55);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
